// File: rtl/pad_bank_dir_ctrl_if.sv
// Signal bundle between the tile interface controller, the pad bank sequencer
// and the pad wrapper cells of one bidirectional I/O bank.
interface pad_bank_dir_ctrl_if #(
  parameter int NPADS = 8
);
  logic             dir_req_valid;
  logic             dir_req_out;
  logic             dir_req_ready;
  logic             cfg_we;
  logic [1:0]       cfg_ds;
  logic             cfg_sr;
  logic [NPADS-1:0] tx_data;
  logic [NPADS-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
  logic [NPADS-1:0] pad_a;
  logic             pad_oe;
  logic             pad_ie;
  logic             pad_ds0;
  logic             pad_ds1;
  logic             pad_sr;
  logic [NPADS-1:0] pad_y;

  modport master (
    output dir_req_valid, dir_req_out, cfg_we, cfg_ds, cfg_sr, tx_data, pad_y,
    input  dir_req_ready, rx_data, rx_valid, busy, pad_a, pad_oe, pad_ie,
           pad_ds0, pad_ds1, pad_sr
  );

  modport slave (
    input  dir_req_valid, dir_req_out, cfg_we, cfg_ds, cfg_sr, tx_data, pad_y,
    output dir_req_ready, rx_data, rx_valid, busy, pad_a, pad_oe, pad_ie,
           pad_ds0, pad_ds1, pad_sr
  );
endinterface

// File: rtl/pad_bank_dir_ctrl.sv
// Direction and drive-config sequencer for a bank of pads sharing one OE/IE set.
// Every direction change passes through TA_CYCLES cycles with both OE and IE low.
module pad_bank_dir_ctrl #(
  parameter int NPADS       = 8,
  parameter int TA_CYCLES   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  pad_bank_dir_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IN,
    ST_TA_OUT,
    ST_OUT,
    ST_TA_IN
  } state_t;

  localparam logic [3:0] TA_LAST = 4'(TA_CYCLES - 1);
  localparam logic [2:0] SYNC_N  = 3'(SYNC_STAGES);

  state_t           r_state;
  state_t           w_nextState;
  logic [3:0]       r_taCnt;
  logic [3:0]       w_taCntNext;
  logic [2:0]       r_inCnt;
  logic [2:0]       w_inCntNext;
  logic             w_accept;
  logic             w_taDone;
  logic             w_inTurn;

  logic             w_oe;
  logic             w_ie;
  logic             w_ready;
  logic             w_busy;
  logic             w_rxValid;

  logic             r_oe;
  logic             r_ie;
  logic             r_ready;
  logic             r_busy;
  logic             r_rxValid;
  logic [1:0]       r_ds;
  logic             r_sr;
  logic [NPADS-1:0] r_padA;
  logic [NPADS-1:0] r_sync [SYNC_STAGES];

  assign w_accept = bus.dir_req_valid && ((r_state == ST_IN) || (r_state == ST_OUT));
  assign w_taDone = (r_taCnt == TA_LAST);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_STARTUP: if (w_taDone) w_nextState = ST_IN;
      ST_IN:      if (w_accept && bus.dir_req_out) w_nextState = ST_TA_OUT;
      ST_TA_OUT:  if (w_taDone) w_nextState = ST_OUT;
      ST_OUT:     if (w_accept && !bus.dir_req_out) w_nextState = ST_TA_IN;
      ST_TA_IN:   if (w_taDone) w_nextState = ST_IN;
      default:    w_nextState = ST_STARTUP;
    endcase
  end

  // Dead-cycle counter counts up from 0 so the post-reset value of 0 also times STARTUP.
  always_comb begin
    w_inTurn    = ((r_state == ST_STARTUP) || (r_state == ST_TA_OUT) ||
                   (r_state == ST_TA_IN)) && (w_nextState == r_state);
    w_taCntNext = w_inTurn ? (r_taCnt + 4'd1) : 4'd0;
    if ((r_state == ST_IN) && (w_nextState == ST_IN))
      w_inCntNext = (r_inCnt == SYNC_N) ? r_inCnt : (r_inCnt + 3'd1);
    else
      w_inCntNext = 3'd0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_STARTUP;
      r_taCnt <= 4'd0;
      r_inCnt <= 3'd0;
    end else begin
      r_state <= w_nextState;
      r_taCnt <= w_taCntNext;
      r_inCnt <= w_inCntNext;
    end
  end

  // Outputs decode the next state so the pads switch on the same edge as the FSM.
  always_comb begin
    w_oe      = (w_nextState == ST_OUT);
    w_ie      = (w_nextState == ST_IN);
    w_ready   = w_oe || w_ie;
    w_busy    = !w_ready;
    w_rxValid = w_ie && (w_inCntNext == SYNC_N);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_oe      <= 1'b0;
      r_ie      <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b1;
      r_rxValid <= 1'b0;
    end else begin
      r_oe      <= w_oe;
      r_ie      <= w_ie;
      r_ready   <= w_ready;
      r_busy    <= w_busy;
      r_rxValid <= w_rxValid;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ds <= 2'b00;
      r_sr <= 1'b0;
    end else if (bus.cfg_we && (r_state != ST_OUT)) begin
      r_ds <= bus.cfg_ds;
      r_sr <= bus.cfg_sr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_padA <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_padA    <= bus.tx_data;
      r_sync[0] <= bus.pad_y;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign bus.dir_req_ready = r_ready;
  assign bus.busy          = r_busy;
  assign bus.pad_oe        = r_oe;
  assign bus.pad_ie        = r_ie;
  assign bus.rx_valid      = r_rxValid;
  assign bus.rx_data       = r_sync[SYNC_STAGES-1];
  assign bus.pad_a         = r_padA;
  assign bus.pad_ds0       = r_ds[0];
  assign bus.pad_ds1       = r_ds[1];
  assign bus.pad_sr        = r_sr;

endmodule
